// File: rtl/hazard_ctrl_pkg.sv
// Shared RISC-V definitions: register file geometry and hazard-controller types.
package _pkg_riscv_defines;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS       = 1 << REG_ADDR_WIDTH;

  localparam int unsigned HZ_MAX_PEND  = 3;
  localparam int unsigned HZ_CNT_WIDTH = $clog2(HZ_MAX_PEND + 1);

  typedef enum logic {
    HZ_RUN,
    HZ_STALL
  } hz_state_t;

  // Register usage of one decoded instruction, as seen by the hazard check
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic                      rs1_used;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic                      rs2_used;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_we;
  } hz_chk_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode / writeback side-band bundle for the hazard controller.
interface hazard_ctrl_if;
  import _pkg_riscv_defines::*;

  logic                      chk_valid;
  logic [REG_ADDR_WIDTH-1:0] chk_rs1_addr;
  logic                      chk_rs1_used;
  logic [REG_ADDR_WIDTH-1:0] chk_rs2_addr;
  logic                      chk_rs2_used;
  logic [REG_ADDR_WIDTH-1:0] chk_rd_addr;
  logic                      chk_rd_we;
  logic                      issue_fire;
  logic [REG_ADDR_WIDTH-1:0] issue_rd_addr;
  logic                      issue_rd_we;
  logic                      wb_valid;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr;
  logic                      flush;
  logic                      pause;
  logic                      err_underflow;

  modport master (
    output chk_valid, chk_rs1_addr, chk_rs1_used, chk_rs2_addr, chk_rs2_used,
           chk_rd_addr, chk_rd_we, issue_fire, issue_rd_addr, issue_rd_we,
           wb_valid, wb_rd_addr, flush,
    input  pause, err_underflow
  );

  modport slave (
    input  chk_valid, chk_rs1_addr, chk_rs1_used, chk_rs2_addr, chk_rs2_used,
           chk_rd_addr, chk_rd_we, issue_fire, issue_rd_addr, issue_rd_we,
           wb_valid, wb_rd_addr, flush,
    output pause, err_underflow
  );

endinterface

// File: rtl/hazard_ctrl_pend_table.sv
// Per-register pending-write counters with same-cycle writeback bypass on three read ports.
module hz_pend_table
  import _pkg_riscv_defines::*;
#(
  parameter int unsigned MAX_PEND = HZ_MAX_PEND,
  parameter int unsigned CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      issue_fire,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd_addr,
  input  logic                      issue_rd_we,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [CNT_W-1:0]          rs1_eff,
  output logic [CNT_W-1:0]          rs2_eff,
  output logic [CNT_W-1:0]          rd_eff,
  output logic                      err_underflow
);

  localparam int unsigned AW = REG_ADDR_WIDTH;

  // x0 has no storage; it reads as never pending
  logic [CNT_W-1:0] cnt_q [1:NUM_REGS-1];
  logic [CNT_W-1:0] cnt_d [1:NUM_REGS-1];
  logic             err_d;

  function automatic logic [CNT_W-1:0] cnt_of(input logic [AW-1:0] a);
    return (a == '0) ? '0 : cnt_q[a];
  endfunction

  function automatic logic [CNT_W-1:0] eff_of(input logic [AW-1:0] a);
    logic [CNT_W-1:0] c;
    c = cnt_of(a);
    return c - CNT_W'(wb_valid && (wb_rd_addr == a) && (c != '0));
  endfunction

  assign rs1_eff = eff_of(rs1_addr);
  assign rs2_eff = eff_of(rs2_addr);
  assign rd_eff  = eff_of(rd_addr);

  // Next counts: flush wins; issue+retire on one register cancel out
  always_comb begin
    logic inc;
    logic dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      inc      = issue_fire && issue_rd_we && (issue_rd_addr == AW'(r));
      dec      = wb_valid && (wb_rd_addr == AW'(r));
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (inc && !dec && (cnt_q[r] != CNT_W'(MAX_PEND))) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec && !inc && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
    err_d = err_underflow
          | (!flush && wb_valid && (wb_rd_addr != '0) && (cnt_of(wb_rd_addr) == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) cnt_q[r] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      err_underflow <= err_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// RAW/WAW scoreboard hazard controller: drives decode pause until conflicting writes retire.
module hazard_ctrl
  import _pkg_riscv_defines::*;
#(
  parameter int unsigned MAX_PEND = HZ_MAX_PEND
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);

  hz_state_t        state_q, state_d;
  hz_chk_t          lat_q, lat_d;
  hz_chk_t          chk_cur, sel;
  logic [CNT_W-1:0] rs1_eff, rs2_eff, rd_eff;
  logic             hz;
  logic             pause_c;

  assign chk_cur = hz_chk_t'{
    rs1_addr: bus.chk_rs1_addr, rs1_used: bus.chk_rs1_used,
    rs2_addr: bus.chk_rs2_addr, rs2_used: bus.chk_rs2_used,
    rd_addr:  bus.chk_rd_addr,  rd_we:    bus.chk_rd_we
  };

  // While stalled the latched instruction is re-checked, live decode is ignored
  assign sel = (state_q == HZ_STALL) ? lat_q : chk_cur;

  hz_pend_table #(
    .MAX_PEND (MAX_PEND),
    .CNT_W    (CNT_W)
  ) u_pend (
    .clk           (clk),
    .rst           (rst),
    .flush         (bus.flush),
    .issue_fire    (bus.issue_fire),
    .issue_rd_addr (bus.issue_rd_addr),
    .issue_rd_we   (bus.issue_rd_we),
    .wb_valid      (bus.wb_valid),
    .wb_rd_addr    (bus.wb_rd_addr),
    .rs1_addr      (sel.rs1_addr),
    .rs2_addr      (sel.rs2_addr),
    .rd_addr       (sel.rd_addr),
    .rs1_eff       (rs1_eff),
    .rs2_eff       (rs2_eff),
    .rd_eff        (rd_eff),
    .err_underflow (bus.err_underflow)
  );

  assign hz = (sel.rs1_used && (rs1_eff != '0))
           || (sel.rs2_used && (rs2_eff != '0))
           || (sel.rd_we    && (rd_eff == CNT_W'(MAX_PEND)));

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    pause_c = 1'b0;
    if (bus.flush) begin
      state_d = HZ_RUN;
      lat_d   = '0;
    end else begin
      case (state_q)
        HZ_RUN: begin
          pause_c = bus.chk_valid && hz;
          if (pause_c) begin
            lat_d   = chk_cur;
            state_d = HZ_STALL;
          end
        end
        HZ_STALL: begin
          pause_c = hz;
          if (!hz) state_d = HZ_RUN;
        end
        default: state_d = HZ_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_RUN;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  assign bus.pause = pause_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: RAW/WAW stalls, bypass release, flush, underflow, reset.
module tb_hazard_ctrl;
  import _pkg_riscv_defines::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MAX_PEND(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle();
    bus.chk_valid = 0; bus.chk_rs1_addr = 0; bus.chk_rs1_used = 0;
    bus.chk_rs2_addr = 0; bus.chk_rs2_used = 0; bus.chk_rd_addr = 0; bus.chk_rd_we = 0;
    bus.issue_fire = 0; bus.issue_rd_addr = 0; bus.issue_rd_we = 0;
    bus.wb_valid = 0; bus.wb_rd_addr = 0; bus.flush = 0;
  endtask

  // Advance to just after the next rising edge and return all inputs to idle
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.issue_fire = 1; bus.issue_rd_addr = rd; bus.issue_rd_we = 1;
  endtask

  task automatic wb(input logic [4:0] rd);
    bus.wb_valid = 1; bus.wb_rd_addr = rd;
  endtask

  task automatic ask(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic we);
    bus.chk_valid = 1;
    bus.chk_rs1_addr = rs1; bus.chk_rs1_used = u1;
    bus.chk_rs2_addr = rs2; bus.chk_rs2_used = u2;
    bus.chk_rd_addr  = rd;  bus.chk_rd_we    = we;
  endtask

  task automatic expect_pause(input string tag, input logic exp);
    #1;
    check(tag, bus.pause, exp);
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;

    // Reset state
    expect_pause("rst_pause", 0);
    check("rst_err", bus.err_underflow, 0);
    ask(5'd5, 1, 5'd6, 1, 5'd7, 1);
    expect_pause("rst_empty_chk", 0);
    tick();

    // RAW on x5, stall, issue x6 while paused, bypass release
    issue(5'd5);
    expect_pause("raw_issue_cyc", 0);
    tick();
    ask(5'd5, 1, 5'd0, 0, 5'd1, 1);
    expect_pause("raw_enter", 1);
    tick();
    expect_pause("raw_hold1", 1);
    tick();
    issue(5'd6);
    expect_pause("raw_hold2", 1);
    tick();
    ask(5'd0, 0, 5'd0, 0, 5'd0, 0);
    expect_pause("raw_hold3_chk_ignored", 1);
    tick();
    wb(5'd5);
    expect_pause("raw_bypass_release", 0);
    tick();
    expect_pause("raw_run_idle", 0);
    ask(5'd5, 1, 5'd0, 0, 5'd0, 0);
    expect_pause("raw_x5_cleared", 0);
    ask(5'd6, 1, 5'd0, 0, 5'd0, 0);
    expect_pause("issue_during_pause_counted", 1);
    idle();
    wb(5'd6);
    tick();

    // x0 is never pending; unused source ignored
    issue(5'd0);
    tick();
    ask(5'd0, 1, 5'd0, 1, 5'd0, 1);
    expect_pause("x0_never_pending", 0);
    idle();
    issue(5'd7);
    tick();
    ask(5'd0, 0, 5'd7, 0, 5'd0, 0);
    expect_pause("rs2_unused", 0);
    ask(5'd0, 0, 5'd7, 1, 5'd0, 0);
    expect_pause("rs2_used", 1);
    idle();
    wb(5'd7);
    tick();

    // Two pending writes to x3
    issue(5'd3);
    tick();
    issue(5'd3);
    tick();
    ask(5'd0, 0, 5'd3, 1, 5'd0, 0);
    expect_pause("x3_enter", 1);
    tick();
    wb(5'd3);
    expect_pause("x3_first_wb", 1);
    tick();
    expect_pause("x3_still", 1);
    wb(5'd3);
    expect_pause("x3_second_wb", 0);
    tick();

    // WAW guard on x9 at MAX_PEND
    issue(5'd9); tick();
    issue(5'd9); tick();
    issue(5'd9); tick();
    ask(5'd0, 0, 5'd0, 0, 5'd9, 1);
    expect_pause("waw_enter", 1);
    tick();
    expect_pause("waw_hold", 1);
    wb(5'd9);
    expect_pause("waw_release", 0);
    tick();
    ask(5'd0, 0, 5'd0, 0, 5'd9, 1);
    expect_pause("waw_two_left_ok", 0);
    idle();
    wb(5'd9); tick();
    wb(5'd9); tick();

    // Simultaneous issue and retire to x10: net zero change
    issue(5'd10);
    tick();
    issue(5'd10);
    wb(5'd10);
    tick();
    ask(5'd10, 1, 5'd0, 0, 5'd0, 0);
    expect_pause("x10_net_zero", 1);
    wb(5'd10);
    expect_pause("x10_run_bypass", 0);
    tick();

    // Flush mid-stall with simultaneous issue to x4
    issue(5'd4); tick();
    issue(5'd4); tick();
    ask(5'd4, 1, 5'd0, 0, 5'd0, 0);
    expect_pause("flush_enter", 1);
    tick();
    expect_pause("flush_stalled", 1);
    bus.flush = 1;
    issue(5'd4);
    expect_pause("flush_cycle_pause", 0);
    tick();
    expect_pause("flush_after_idle", 0);
    ask(5'd4, 1, 5'd0, 0, 5'd4, 1);
    expect_pause("flush_x4_cleared", 0);
    tick();

    // Underflow is sticky through flush; reset clears everything
    wb(5'd12);
    #1;
    check("uf_not_yet", bus.err_underflow, 0);
    tick();
    check("uf_set", bus.err_underflow, 1);
    bus.flush = 1;
    tick();
    check("uf_after_flush", bus.err_underflow, 1);
    issue(5'd12);
    tick();
    ask(5'd12, 1, 5'd0, 0, 5'd0, 0);
    expect_pause("rst_stall_enter", 1);
    tick();
    expect_pause("rst_stalled", 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("rst2_err", bus.err_underflow, 0);
    expect_pause("rst2_pause", 0);
    ask(5'd12, 1, 5'd0, 0, 5'd0, 0);
    expect_pause("rst2_x12_cleared", 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Scoreboard-based RAW/WAW hazard controller for the in-order pipeline; drives the `pause` input of the decode stage.
- Tracks, per architectural register, how many issued instructions still have a pending write to it.
- Checks each decoded instruction's source and destination registers against that table, and holds `pause` until every conflicting write has retired at writeback.
- Sits between decode (check and issue events) and writeback (retire events).

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5 (package): register address width; 2^5 = 32 registers.
- `MAX_PEND`, 3: maximum outstanding writes per register; counter width is `$clog2(MAX_PEND+1)`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` input 1: single clock; all state updates on its rising edge.
  - `rst` input 1: synchronous reset.
- Check (from decode):
  - `chk_valid` input 1: decoded instruction presented for hazard check (idecoder response cycle).
  - `chk_rs1_addr` input 5, `chk_rs1_used` input 1: source 1 address and whether it is read.
  - `chk_rs2_addr` input 5, `chk_rs2_used` input 1: source 2 address and whether it is read.
  - `chk_rd_addr` input 5, `chk_rd_we` input 1: destination address and whether it is written.
- Issue (decode → execute):
  - `issue_fire` input 1: decode-to-execute valid&&ready handshake.
  - `issue_rd_addr` input 5, `issue_rd_we` input 1: destination of the issued instruction.
- Retire (writeback):
  - `wb_valid` input 1: register-file write this cycle.
  - `wb_rd_addr` input 5: register written.
- Other:
  - `flush` input 1: discard all in-flight instructions (branch redirect).
  - `pause` output 1: hold the decode stage.
  - `err_underflow` output 1: sticky; set on a retire to a register with count 0.

## Operation
- **Pending table:** `pend[r]` exists for r = 1..31; `pend[0]` is constant 0, so x0 is never pending.
  - Issue increments `pend[issue_rd_addr]` when `issue_fire && issue_rd_we && issue_rd_addr != 0`.
  - Retire decrements `pend[wb_rd_addr]` when `wb_valid && wb_rd_addr != 0`.
  - Issue and retire to the same register in the same cycle: net change 0.
  - Retire with `pend` = 0: count stays 0 and `err_underflow` is set.
- **Effective count:** `eff[r] = pend[r] - (wb_valid && wb_rd_addr == r && pend[r] != 0)`. This is a same-cycle writeback bypass.
- **Hazard (`hz`) is true when any of the following hold:**
  - `rs1_used && eff[rs1] != 0`.
  - `rs2_used && eff[rs2] != 0`.
  - `rd_we && eff[rd] == MAX_PEND` (WAW overflow guard).
- **State machine:**
  - State type `hz_state_t`: `HZ_RUN`, `HZ_STALL`.
  - `HZ_RUN`:
    - `pause = chk_valid && hz(chk_*)`.
    - When `pause` = 1, latch `chk_*` into `lat_*` and go to `HZ_STALL`.
  - `HZ_STALL`:
    - `pause = hz(lat_*)`; `chk_*` are ignored.
    - When `hz(lat_*)` = 0, `pause` = 0 and go to `HZ_RUN`.
  - Decode re-requests its decoder on the falling edge of `pause`, and the fresh response is checked again in `HZ_RUN`.
- **Flush:**
  - Next edge: all `pend` = 0, state `HZ_RUN`, `lat_*` cleared.
  - Flush has priority over simultaneous issue and retire.
  - `pause` is forced to 0 in the flush cycle.
  - `err_underflow` is not cleared by flush.
- **Reset:** all `pend` = 0, state `HZ_RUN`, `lat_*` = 0, `err_underflow` = 0. This gives `pause` = 0 after reset.

## Timing
- `pause` is combinational from `chk_*`, `wb_*` and the registered table, so stall entry has 0-cycle latency. This is required: decode samples the decoder response in the same cycle, gated by `~pause`.
- Stall release: `pause` drops in the same cycle that `wb_valid` retires the last conflicting write (bypass). The state returns to `HZ_RUN` at the following edge.
- Issue and retire update `pend` at the edge ending the handshake cycle, so the next cycle's check sees the update.
- `rst` asserted mid-stall: `pause` goes to 0 at the first edge with `rst` high, and the table is cleared.
- `issue_fire` while `pause` = 1 is legal: decode may still hand over a previously decoded instruction. It is counted normally.

## Structure
- Shared package `_pkg_riscv_defines`:
  - Add `hz_state_t`.
  - Add `HZ_MAX_PEND` (default 3) and `HZ_CNT_WIDTH`.
  - Reuse `REG_ADDR_WIDTH`.
- Sub-module `hz_pend_table` holds:
  - the 31 saturating up/down counters;
  - the bypassed `eff` lookups, with three read ports (rs1, rs2, rd);
  - the underflow flag.
- `hazard_ctrl` holds the state machine, the latches and the flush/reset priority.

## Test plan
- **RAW stall and bypass release:**
  - Stimulus: issue rd = x5; next cycle check rs1 = x5 (used).
  - Expected: `pause` = 1 immediately. Hold 4 cycles, then `wb_valid` to x5: `pause` = 0 in that cycle; `HZ_RUN` next cycle.
- **x0 and unused source:**
  - Stimulus: issue rd = x0; check rs1 = x0. Separately, check rs2 = x7 with `rs2_used` = 0 while `pend[7]` = 1.
  - Expected: `pause` = 0 in both cases.
- **Two pending writes to x3:**
  - Stimulus: issue rd = x3 twice; check rs2 = x3; first writeback to x3.
  - Expected: `pause` stays 1 after the first writeback; drops at the second writeback.
- **WAW guard:**
  - Stimulus: 3 issues to x9, then check with `rd_we` = 1, rd = x9.
  - Expected: `pause` = 1; released in the cycle of the first x9 writeback.
- **Flush mid-stall:**
  - Stimulus: `pend[4]` = 2 with decode stalled on rs1 = x4; assert `flush` together with `issue_fire` to x4.
  - Expected: `pause` = 0 in that cycle; next cycle `pend[4]` = 0, state `HZ_RUN`.
- **Underflow and reset:**
  - Stimulus: writeback to x12 while `pend[12]` = 0; then assert `rst` for one cycle while stalled.
  - Expected: `err_underflow` = 1 and stays set through flush; after the reset edge, `err_underflow` = 0, `pause` = 0, all counts 0.
